// File: rtl/knob_value_display.sv
// knob_value_display: saturating 8-bit encoder/button value rendered as a 2x16 LCD frame.
// Decimal digits come from a one-bit-per-clock double-dabble on a snapshot of the value.
module knob_value_display #(
    parameter int MAX_VALUE = 255,
    parameter int BIG_STEP  = 10
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic [1:0]   iKnob,
    input  logic [4:0]   iBTN,
    output logic [7:0]   oValue,
    output logic [256:0] oChars,
    output logic         oUpdate,
    output logic         oBusy
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam logic [127:0]       LINE1  = {"KN", "OB VALUE      "};
    localparam logic signed [9:0]  MAX_S  = 10'(MAX_VALUE);
    localparam logic signed [9:0]  STEP_S = 10'(BIG_STEP);

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [255:0] make_frame(input logic [11:0] bcd, input logic [7:0] hx);
        return {LINE1, "DEC ", {4'h3, bcd[11:8]}, {4'h3, bcd[7:4]}, {4'h3, bcd[3:0]},
                "  HEX ", hex_char(hx[7:4]), hex_char(hx[3:0]), " "};
    endfunction

    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int i = 0; i < 3; i++)
            if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

    state_t             state, state_d;
    logic [7:0]         value, value_d, snap;
    logic [4:0]         btn_prev, rise;
    logic               dirty, dirty_d, changed, unused_lr;
    logic [2:0]         cnt;
    logic [19:0]        dd;
    logic [255:0]       frame;
    logic signed [9:0]  knob_d, btn_d, sum;

    // iBTN = {UP, DOWN, LEFT, RIGHT, CNTR}; LEFT/RIGHT have no function here
    assign rise      = iBTN & ~btn_prev;
    assign unused_lr = ^rise[2:1];

    always_comb begin
        knob_d  = iKnob[1] ? (iKnob[0] ? -10'sd1 : 10'sd1) : 10'sd0;
        btn_d   = (rise[4] ? STEP_S : 10'sd0) - (rise[3] ? STEP_S : 10'sd0);
        sum     = $signed({2'b00, value}) + knob_d + btn_d;
        value_d = rise[0] ? 8'd0 : (sum < 10'sd0) ? 8'd0 : (sum > MAX_S) ? MAX_S[7:0] : sum[7:0];
        changed = value_d != value;
    end

    // A change landing in the snapshot cycle re-arms dirty so it gets its own frame
    always_comb begin
        state_d = state;
        dirty_d = dirty | changed;
        case (state)
            IDLE: if (dirty) begin
                state_d = CONV;
                dirty_d = changed;
            end
            CONV: if (cnt == 3'd7) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            value    <= 8'd0;
            btn_prev <= 5'd0;
            dirty    <= 1'b0;
            snap     <= 8'd0;
            dd       <= 20'd0;
            cnt      <= 3'd0;
            oUpdate  <= 1'b0;
            frame    <= make_frame(12'd0, 8'd0);
        end else begin
            state    <= state_d;
            value    <= value_d;
            btn_prev <= iBTN;
            dirty    <= dirty_d;
            oUpdate  <= state == DONE;
            if (state == IDLE && dirty) begin
                snap <= value;
                dd   <= {12'd0, value};
                cnt  <= 3'd0;
            end
            if (state == CONV) begin
                dd  <= dd_step(dd);
                cnt <= cnt + 3'd1;
            end
            if (state == DONE) frame <= make_frame(dd[19:8], snap);
        end
    end

    assign oValue = value;
    assign oChars = {1'b0, frame};
    assign oBusy  = state != IDLE;
endmodule

// File: tb/tb_knob_value_display.sv
// tb_knob_value_display: directed checks of value arithmetic, frame contents and timing.
module tb_knob_value_display;
    logic         CLK = 1'b0, Reset = 1'b0;
    logic [1:0]   iKnob = 2'b00;
    logic [4:0]   iBTN = 5'b00000;
    logic [7:0]   value_a, value_b;
    logic [256:0] chars_a, chars_b;
    logic         upd_a, upd_b, busy_a, busy_b;
    int           checks = 0, errors = 0, upd_cnt = 0, u0 = 0, n = 0;

    localparam logic [256:0] RESET_FRAME = {1'b0, "KN", "OB VALUE      ", "DEC 000  HEX 00 "};
    localparam logic [4:0] UP = 5'b10000, DOWN = 5'b01000, CNTR = 5'b00001;

    knob_value_display dut_a (
        .CLK(CLK), .Reset(Reset), .iKnob(iKnob), .iBTN(iBTN),
        .oValue(value_a), .oChars(chars_a), .oUpdate(upd_a), .oBusy(busy_a)
    );

    knob_value_display #(.MAX_VALUE(200)) dut_b (
        .CLK(CLK), .Reset(Reset), .iKnob(iKnob), .iBTN(iBTN),
        .oValue(value_b), .oChars(chars_b), .oUpdate(upd_b), .oBusy(busy_b)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (upd_a) upd_cnt++;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_update(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!upd_a && cnt < 40);
    endtask

    task automatic press(input logic [4:0] b, input int hold);
        iBTN = b;
        repeat (hold) tick();
        iBTN = 5'b00000;
        tick();
    endtask

    task automatic turn(input logic dir);
        iKnob = {1'b1, dir};
        tick();
        iKnob = 2'b00;
    endtask

    initial begin
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        chk("reset_value", 257'(value_a), 257'(0));
        chk("reset_busy", 257'(busy_a), 257'(0));
        chk("reset_update", 257'(upd_a), 257'(0));
        chk("reset_frame", chars_a, RESET_FRAME);
        repeat (15) tick();
        chk("idle_no_update", 257'(upd_cnt), 257'(0));

        turn(1'b0);
        chk("knob_value", 257'(value_a), 257'(1));
        chk("knob_not_busy_e0", 257'(busy_a), 257'(0));
        wait_update(n);
        chk("knob_latency", 257'(n), 257'(10));
        chk("knob_line2", 257'(chars_a[127:0]), 257'("DEC 001  HEX 01 "));
        chk("knob_line1", 257'(chars_a[256:128]), 257'({1'b0, "KN", "OB VALUE      "}));
        chk("knob_busy_fall", 257'(busy_a), 257'(0));

        press(CNTR, 1);
        chk("cntr_zero", 257'(value_a), 257'(0));
        repeat (15) tick();
        for (int i = 0; i < 5; i++) press(UP, 3);
        chk("up5_value", 257'(value_a), 257'(50));
        repeat (25) tick();
        chk("up5_line2", 257'(chars_a[127:0]), 257'("DEC 050  HEX 32 "));
        chk("up5_idle", 257'(busy_a), 257'(0));

        press(CNTR, 1);
        repeat (15) tick();
        u0 = upd_cnt;
        press(DOWN, 1);
        chk("down_at_zero", 257'(value_a), 257'(0));
        turn(1'b1);
        chk("dec_at_zero", 257'(value_a), 257'(0));
        repeat (15) tick();
        chk("zero_no_update", 257'(upd_cnt - u0), 257'(0));

        for (int i = 0; i < 25; i++) press(UP, 1);
        chk("up25_value", 257'(value_a), 257'(250));
        chk("b_sat_200", 257'(value_b), 257'(200));
        for (int i = 0; i < 4; i++) turn(1'b0);
        chk("b2b_knob", 257'(value_a), 257'(254));
        iKnob = 2'b10;
        iBTN  = UP;
        tick();
        iKnob = 2'b00;
        iBTN  = 5'b00000;
        chk("sat_255", 257'(value_a), 257'(255));
        chk("b_sat_stay", 257'(value_b), 257'(200));
        repeat (25) tick();
        chk("sat_line2", 257'(chars_a[127:0]), 257'("DEC 255  HEX FF "));
        chk("b_sat_line2", 257'(chars_b[127:0]), 257'("DEC 200  HEX C8 "));
        u0 = upd_cnt;
        turn(1'b0);
        chk("inc_at_max", 257'(value_a), 257'(255));
        repeat (15) tick();
        chk("max_no_update", 257'(upd_cnt - u0), 257'(0));

        press(CNTR, 1);
        repeat (15) tick();
        u0 = upd_cnt;
        turn(1'b0);
        repeat (3) tick();
        chk("busy_in_conv", 257'(busy_a), 257'(1));
        turn(1'b0);
        chk("midconv_value", 257'(value_a), 257'(2));
        wait_update(n);
        chk("first_frame_e10", 257'(n), 257'(6));
        chk("first_frame_line2", 257'(chars_a[127:0]), 257'("DEC 001  HEX 01 "));
        wait_update(n);
        chk("second_frame_e20", 257'(n), 257'(10));
        chk("second_frame_line2", 257'(chars_a[127:0]), 257'("DEC 002  HEX 02 "));
        repeat (15) tick();
        chk("two_updates", 257'(upd_cnt - u0), 257'(2));

        press(CNTR, 1);
        for (int i = 0; i < 7; i++) press(UP, 1);
        for (int i = 0; i < 7; i++) turn(1'b0);
        chk("reach_77", 257'(value_a), 257'(77));
        iBTN  = CNTR;
        iKnob = 2'b10;
        tick();
        iBTN  = 5'b00000;
        iKnob = 2'b00;
        chk("cntr_wins", 257'(value_a), 257'(0));
        repeat (25) tick();
        chk("cntr_line2", 257'(chars_a[127:0]), 257'("DEC 000  HEX 00 "));

        turn(1'b0);
        wait_update(n);
        chk("pre_reset_line2", 257'(chars_a[127:0]), 257'("DEC 001  HEX 01 "));
        repeat (2) tick();
        u0 = upd_cnt;
        turn(1'b0);
        repeat (5) tick();
        chk("busy_before_reset", 257'(busy_a), 257'(1));
        Reset = 1'b0;
        #1;
        chk("abort_value", 257'(value_a), 257'(0));
        chk("abort_busy", 257'(busy_a), 257'(0));
        chk("abort_update", 257'(upd_a), 257'(0));
        chk("abort_frame", chars_a, RESET_FRAME);
        repeat (2) tick();
        Reset = 1'b1;
        repeat (15) tick();
        chk("abort_no_update", 257'(upd_cnt - u0), 257'(0));
        chk("abort_frame_hold", chars_a, RESET_FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
